intersection_phase_scheduler: RTL and testbench

Two-road intersection phase controller that sequences main-road and side-road signal heads through green, yellow and all-red phases from an internally generated 1 Hz tick. Side-road car sensing and a pedestrian button are latched as service requests. Main green holds indefinitely after its minimum time until a request is pending. It drives the light encodings, a 4-bit countdown for the seven-segment decoder, and a phase code for the dot-matrix pattern selector.

---
 rtl/intersection_phase_scheduler_pkg.sv | 26 ++
 rtl/intersection_phase_scheduler_if.sv | 26 ++
 rtl/intersection_phase_scheduler_tick_gen.sv | 24 ++
 rtl/intersection_phase_scheduler.sv | 119 +++++++++++
 tb/tb_intersection_phase_scheduler.sv | 205 ++++++++++++++++++++
 5 files changed

// File: rtl/intersection_phase_scheduler_pkg.sv
// Shared constants for the intersection phase scheduler:
// light encodings, phase codes and default phase timing.
package traffic_pkg;

  localparam logic [1:0] S_green  = 2'b00;
  localparam logic [1:0] S_yellow = 2'b01;
  localparam logic [1:0] S_red    = 2'b10;

  localparam logic [2:0] MAIN_GREEN  = 3'd0;
  localparam logic [2:0] MAIN_YELLOW = 3'd1;
  localparam logic [2:0] ALL_RED_A   = 3'd2;
  localparam logic [2:0] SIDE_GREEN  = 3'd3;
  localparam logic [2:0] SIDE_YELLOW = 3'd4;
  localparam logic [2:0] ALL_RED_B   = 3'd5;

  localparam int DEF_TICK_DIV     = 50_000_000;
  localparam int DEF_MAIN_MIN     = 10;
  localparam int DEF_YELLOW_T     = 3;
  localparam int DEF_ALLRED_T     = 1;
  localparam int DEF_SIDE_GREEN_T = 8;

  function automatic logic load_ok(input int v);
    return (v >= 0) && (v <= 15);
  endfunction

endpackage

// File: rtl/intersection_phase_scheduler_if.sv
// Request inputs and signal-head outputs of the scheduler.
// The controller sits on the slave side.
interface intersection_phase_scheduler_if;

  logic       side_req;
  logic       ped_btn;
  logic [1:0] main_light;
  logic [1:0] side_light;
  logic       ped_walk;
  logic [3:0] countdown;
  logic [2:0] phase;
  logic       tick;

  modport master (
    output side_req, ped_btn,
    input  main_light, side_light, ped_walk,
    input  countdown, phase, tick
  );

  modport slave (
    input  side_req, ped_btn,
    output main_light, side_light, ped_walk,
    output countdown, phase, tick
  );

endinterface

// File: rtl/intersection_phase_scheduler_tick_gen.sv
// Free-running prescaler: tick_o is high for one clk
// every DIV cycles, while the count sits at DIV-1.
module tick_gen #(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst_n,
  output logic tick_o
);

  localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
  localparam logic [W-1:0] LAST = W'(DIV - 1);

  logic [W-1:0] cnt_q, cnt_d;

  assign cnt_d  = (cnt_q == LAST) ? '0 : cnt_q + 1'b1;
  assign tick_o = (cnt_q == LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= '0;
    else        cnt_q <= cnt_d;
  end

endmodule

// File: rtl/intersection_phase_scheduler.sv
// Two-road phase controller: 1 Hz countdown FSM with a
// latched side/pedestrian request that releases main green.
module intersection_phase_scheduler
  import traffic_pkg::*;
#(
  parameter int TICK_DIV     = DEF_TICK_DIV,
  parameter int MAIN_MIN     = DEF_MAIN_MIN,
  parameter int YELLOW_T     = DEF_YELLOW_T,
  parameter int ALLRED_T     = DEF_ALLRED_T,
  parameter int SIDE_GREEN_T = DEF_SIDE_GREEN_T
) (
  input logic clk,
  input logic reset,
  intersection_phase_scheduler_if.slave bus
);

  if (!(load_ok(MAIN_MIN) && load_ok(YELLOW_T) &&
        load_ok(ALLRED_T) && load_ok(SIDE_GREEN_T)) ||
      (TICK_DIV < 2)) begin : g_bad_param
    $error("intersection_phase_scheduler: bad parameter");
  end

  localparam logic [3:0] L_MAIN = 4'(MAIN_MIN);
  localparam logic [3:0] L_YEL  = 4'(YELLOW_T);
  localparam logic [3:0] L_AR   = 4'(ALLRED_T);
  localparam logic [3:0] L_SG   = 4'(SIDE_GREEN_T);

  logic       tick;
  logic [2:0] phase_q, phase_d;
  logic [3:0] cnt_q, cnt_d;
  logic       pending_q, pending_d;
  logic       enter_side;
  logic [1:0] main_l, side_l;

  tick_gen #(.DIV(TICK_DIV)) u_tick (
    .clk    (clk),
    .rst_n  (reset),
    .tick_o (tick)
  );

  assign enter_side = tick && (phase_q == ALL_RED_A) &&
                      (cnt_q == 4'd0);

  // A request arriving on the entry clk survives the clear.
  assign pending_d = bus.side_req | bus.ped_btn |
                     (pending_q & ~enter_side);

  always_comb begin
    phase_d = phase_q;
    cnt_d   = cnt_q;
    if (phase_q > ALL_RED_B) begin
      phase_d = MAIN_GREEN;
      cnt_d   = L_MAIN;
    end else if (tick) begin
      if (cnt_q != 4'd0) begin
        cnt_d = cnt_q - 4'd1;
      end else begin
        unique case (phase_q)
          MAIN_GREEN: if (pending_q) begin
            phase_d = MAIN_YELLOW;
            cnt_d   = L_YEL;
          end
          MAIN_YELLOW: begin
            phase_d = ALL_RED_A;
            cnt_d   = L_AR;
          end
          ALL_RED_A: begin
            phase_d = SIDE_GREEN;
            cnt_d   = L_SG;
          end
          SIDE_GREEN: begin
            phase_d = SIDE_YELLOW;
            cnt_d   = L_YEL;
          end
          SIDE_YELLOW: begin
            phase_d = ALL_RED_B;
            cnt_d   = L_AR;
          end
          default: begin
            phase_d = MAIN_GREEN;
            cnt_d   = L_MAIN;
          end
        endcase
      end
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      phase_q   <= MAIN_GREEN;
      cnt_q     <= L_MAIN;
      pending_q <= 1'b0;
    end else begin
      phase_q   <= phase_d;
      cnt_q     <= cnt_d;
      pending_q <= pending_d;
    end
  end

  always_comb begin
    main_l = S_red;
    side_l = S_red;
    unique case (1'b1)
      (phase_q == MAIN_GREEN):  main_l = S_green;
      (phase_q == MAIN_YELLOW): main_l = S_yellow;
      (phase_q == SIDE_GREEN):  side_l = S_green;
      (phase_q == SIDE_YELLOW): side_l = S_yellow;
      default: ;
    endcase
  end

  assign bus.main_light = main_l;
  assign bus.side_light = side_l;
  assign bus.ped_walk   = (phase_q == SIDE_GREEN);
  assign bus.countdown  = cnt_q;
  assign bus.phase      = phase_q;
  assign bus.tick       = tick;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with
// TICK_DIV=4, MAIN_MIN=3, YELLOW_T=2, ALLRED_T=1, SIDE_GREEN_T=4.
module tb_intersection_phase_scheduler;

  logic clk = 1'b0;
  logic reset = 1'b0;

  always #5 clk = ~clk;

  intersection_phase_scheduler_if bus ();

  intersection_phase_scheduler #(
    .TICK_DIV     (4),
    .MAIN_MIN     (3),
    .YELLOW_T     (2),
    .ALLRED_T     (1),
    .SIDE_GREEN_T (4)
  ) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;

  int          dur [8];
  logic [23:0] seq;
  int          walk;
  int          viol;

  task automatic check(input string tag,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Returns at the negedge just after a tick edge.
  task automatic step_tick();
    int n = 0;
    @(negedge clk);
    while (bus.tick !== 1'b1 && n < 16) begin
      @(negedge clk);
      n++;
    end
    if (n == 16) check("tick_timeout", 32'(bus.tick), 1);
    @(negedge clk);
  endtask

  task automatic step_until(input string tag,
                            input logic [2:0] p,
                            input logic [3:0] c);
    int n = 0;
    do begin
      step_tick();
      n++;
    end while (!(bus.phase == p && bus.countdown == c) && n < 40);
    check(tag, {bus.phase, bus.countdown}, {p, c});
  endtask

  task automatic pulse_side();
    bus.side_req = 1'b1;
    @(negedge clk);
    bus.side_req = 1'b0;
  endtask

  // Runs from a non-main phase until main green is re-entered.
  task automatic run_cycle();
    logic [2:0] last = 3'd7;
    int n = 0;
    for (int i = 0; i < 8; i++) dur[i] = 0;
    seq = '0;
    walk = 0;
    viol = 0;
    while (n < 200) begin
      if (bus.phase != last) begin
        seq = {seq[19:0], 1'b0, bus.phase};
        last = bus.phase;
      end
      if (bus.phase == 3'd0 && n > 0) break;
      dur[bus.phase]++;
      walk += int'(bus.ped_walk);
      if (bus.main_light == 2'b00 && bus.side_light != 2'b10)
        viol++;
      @(negedge clk);
      n++;
    end
    if (n == 200) check("cycle_timeout", 32'(bus.phase), 0);
  endtask

  initial begin
    bus.side_req = 1'b0;
    bus.ped_btn  = 1'b0;

    @(negedge clk);
    check("rst_phase", 32'(bus.phase), 0);
    check("rst_cnt", 32'(bus.countdown), 3);
    check("rst_main", 32'(bus.main_light), 0);
    check("rst_side", 32'(bus.side_light), 2);
    check("rst_walk", 32'(bus.ped_walk), 0);
    check("rst_tick", 32'(bus.tick), 0);
    reset = 1'b1;

    step_tick();
    check("idle_t1", {bus.phase, bus.countdown}, {3'd0, 4'd2});
    step_tick();
    check("idle_t2", {bus.phase, bus.countdown}, {3'd0, 4'd1});
    step_tick();
    check("idle_t3", {bus.phase, bus.countdown}, {3'd0, 4'd0});
    repeat (37) step_tick();
    check("idle_hold", {bus.phase, bus.countdown}, {3'd0, 4'd0});
    check("idle_lights", {bus.main_light, bus.side_light}, 4'b0010);

    bus.ped_btn = 1'b1;
    @(negedge clk);
    bus.ped_btn = 1'b0;
    step_tick();
    check("ped_adv", {bus.phase, bus.countdown}, {3'd1, 4'd2});
    check("ped_mylights", {bus.main_light, bus.side_light}, 4'b0110);
    run_cycle();
    check("ped_walk_clk", walk, 20);
    check("ped_viol", viol, 0);
    check("ped_back", {bus.phase, bus.countdown}, {3'd0, 4'd3});

    step_tick();
    check("full_mg2", {bus.phase, bus.countdown}, {3'd0, 4'd2});
    pulse_side();
    step_tick();
    check("full_mg1", {bus.phase, bus.countdown}, {3'd0, 4'd1});
    step_tick();
    check("full_mg0", {bus.phase, bus.countdown}, {3'd0, 4'd0});
    step_tick();
    check("full_adv", {bus.phase, bus.countdown}, {3'd1, 4'd2});
    run_cycle();
    check("full_seq", seq, 24'h123450);
    check("full_d1", dur[1], 12);
    check("full_d2", dur[2], 8);
    check("full_d3", dur[3], 20);
    check("full_d4", dur[4], 12);
    check("full_d5", dur[5], 8);
    check("full_viol", viol, 0);
    check("full_walk", walk, 20);

    pulse_side();
    step_until("race_ara0", 3'd2, 4'd0);
    begin
      int n = 0;
      while (bus.tick !== 1'b1 && n < 16) begin
        @(negedge clk);
        n++;
      end
    end
    bus.side_req = 1'b1;
    @(negedge clk);
    bus.side_req = 1'b0;
    check("race_sg", {bus.phase, bus.countdown}, {3'd3, 4'd4});
    check("race_sg_lights", {bus.main_light, bus.side_light}, 4'b1000);
    step_until("race_mg", 3'd0, 4'd3);
    step_tick();
    step_tick();
    step_tick();
    check("race_mg0", {bus.phase, bus.countdown}, {3'd0, 4'd0});
    step_tick();
    check("race_adv", {bus.phase, bus.countdown}, {3'd1, 4'd2});

    step_until("late_sy", 3'd4, 4'd2);
    check("late_sylights", {bus.main_light, bus.side_light}, 4'b1001);
    pulse_side();
    step_until("late_mg", 3'd0, 4'd3);
    step_tick();
    step_tick();
    step_tick();
    check("late_mg0", {bus.phase, bus.countdown}, {3'd0, 4'd0});
    step_tick();
    check("late_adv", {bus.phase, bus.countdown}, {3'd1, 4'd2});
    step_until("late_mg2", 3'd0, 4'd3);
    repeat (6) step_tick();
    check("late_cleared", {bus.phase, bus.countdown}, {3'd0, 4'd0});

    pulse_side();
    step_until("rstsg_enter", 3'd3, 4'd4);
    step_tick();
    check("rstsg_mid", {bus.phase, bus.countdown, bus.ped_walk},
          {3'd3, 4'd3, 1'b1});
    #2;
    reset = 1'b0;
    #1;
    check("arst_phase", 32'(bus.phase), 0);
    check("arst_cnt", 32'(bus.countdown), 3);
    check("arst_lights", {bus.main_light, bus.side_light}, 4'b0010);
    check("arst_walk", 32'(bus.ped_walk), 0);
    @(negedge clk);
    reset = 1'b1;
    step_tick();
    check("arst_t1", {bus.phase, bus.countdown}, {3'd0, 4'd2});

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
